det_event_logger: RTL

- Downstream consumer of the 1101 sequence detector's registered `out` pulse.
- Timestamps every detection against a free-running cycle counter and queues the timestamps in a small first-word-fall-through (FWFT) FIFO.
- Software or a bus agent drains the FIFO via a valid/ready handshake.
- Also maintains a saturating detection count and a sticky overflow flag.

---
 rtl/det_event_logger.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/det_event_logger.sv
// det_event_logger
//
// Timestamps every detection pulse from the 1101 sequence detector against a
// free-running cycle counter. The timestamps are queued in a small
// first-word-fall-through FIFO that a consumer drains with a valid/ready
// handshake. The block also keeps a saturating detection count and a sticky
// overflow flag.
//
// Optional feature: define DET_GAP_FILTER_EN to reject detections that arrive
// fewer than MIN_GAP cycles after the previous accepted detection.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   det_in     in   detection pulse, one detection per high cycle
//   clr        in   synchronous clear of FIFO, timestamp, count and overflow
//   evt_valid  out  FIFO holds at least one entry
//   evt_ready  in   consumer takes the head entry
//   evt_ts     out  timestamp at the FIFO head, 0 when empty
//   evt_count  out  accepted detections, saturating
//   fifo_level out  number of queued entries
//   overflow   out  sticky, an accepted detection was dropped on a full FIFO

module det_event_logger #(
   parameter int TS_W    = 16,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 8,
   parameter int MIN_GAP = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       det_in,
   input  logic                       clr,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [TS_W-1:0]            evt_ts,
   output logic [CNT_W-1:0]           evt_count,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // Reject parameter values the pointer arithmetic cannot handle.
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("det_event_logger: DEPTH must be a power of two in 2..16");
   end
   if (MIN_GAP < 1 || MIN_GAP > 255) begin : g_bad_gap
      $error("det_event_logger: MIN_GAP must be in 1..255");
   end

   logic [TS_W-1:0]  ts_cnt;
   logic [TS_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [LVL_W-1:0] level;
   logic             accept;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

`ifdef DET_GAP_FILTER_EN
   localparam int GAP_W = 8;

   logic [GAP_W-1:0] gap;
   logic [GAP_W-1:0] gap_inc;

   // gap holds the number of edges since the last accepted detection, minus
   // one; gap_inc therefore counts the current edge as well, so a pulse
   // exactly MIN_GAP cycles after the previous accept passes. Starting from
   // MIN_GAP makes the first pulse after reset or clear always pass.
   assign gap_inc = (gap >= GAP_W'(MIN_GAP)) ? gap : gap + 1'b1;
   assign accept  = det_in && (gap_inc >= GAP_W'(MIN_GAP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap <= GAP_W'(MIN_GAP);
      end else if (clr) begin
         gap <= GAP_W'(MIN_GAP);
      end else if (accept) begin
         gap <= '0;
      end else begin
         gap <= gap_inc;
      end
   end
`else
   assign accept = det_in;
`endif

   // Clear overrides both sides of the FIFO. When full, a pop on the same
   // edge frees the head slot, which is also the tail slot, so the write
   // can proceed.
   assign full = (level == LVL_W'(DEPTH));
   assign pop  = !clr && (level != '0) && evt_ready;
   assign push = !clr && accept && (!full || pop);
   assign drop = !clr && accept && full && !pop;

   // Timestamp counter, FIFO bookkeeping, detection count and overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt    <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else if (clr) begin
         ts_cnt    <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
         if (accept && (evt_count != '1)) begin
            evt_count <= evt_count + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage has no reset; stale contents are never visible because the
   // head is masked whenever the level is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= ts_cnt;
      end
   end

   assign evt_valid  = (level != '0);
   assign evt_ts     = evt_valid ? mem[rd_ptr] : '0;
   assign fifo_level = level;

endmodule
